accumulator_sequencer: RTL and testbench

//  Micro-sequencer that drives the control word of the adder/accumulator datapath (bus_regA_sel,
//  nLa, nLb, Ea, Eu, sub) from single-word commands. Sits between an external command source and
//  the uio_in control pins of the datapath. Steps each command through fixed T-states, then

---
 rtl/acc_seq_pkg.sv | 71 +++++++
 rtl/acc_seq_decode.sv | 27 ++
 rtl/accumulator_sequencer.sv | 118 +++++++++++
 tb/tb_accumulator_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator micro-sequencer: opcodes, FSM states,
// the datapath control word and the entry-state helper.
package acc_seq_pkg;

    localparam int OP_W  = 3;
    localparam int CNT_W = 3;

    typedef logic [OP_W-1:0]  op_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam op_t OP_NOP = 3'd0;
    localparam op_t OP_LDA = 3'd1;
    localparam op_t OP_LDB = 3'd2;
    localparam op_t OP_ADD = 3'd3;
    localparam op_t OP_SUB = 3'd4;
    localparam op_t OP_ACC = 3'd5;
    localparam op_t OP_OUT = 3'd6;
    localparam op_t OP_RSV = 3'd7;

    // SHOW keeps the accumulator on uo_out for this many cycles.
    localparam int SHOW_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOADA,
        ST_LOADB,
        ST_EXEC,
        ST_FLAG,
        ST_SHOW,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic bus_sel;
        logic n_la;
        logic n_lb;
        logic ea;
        logic eu;
        logic sub;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam ctrl_t CTRL_IDLE = '{
        bus_sel: 1'b1,
        n_la:    1'b1,
        n_lb:    1'b1,
        ea:      1'b0,
        eu:      1'b0,
        sub:     1'b0
    };

    // First state a freshly accepted command enters.
    function automatic state_t entry_state(input op_t op);
        state_t st;
        case (op)
            OP_LDA, OP_LDB, OP_ADD, OP_SUB: st = ST_SETTLE;
            OP_ACC:                         st = ST_EXEC;
            OP_OUT:                         st = ST_SHOW;
            default:                        st = ST_DONE;
        endcase
        return st;
    endfunction

    // ADD and SUB reuse the LDB path to fetch their operand before executing.
    function automatic logic is_arith_load(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/acc_seq_decode.sv
// Combinational decode of the sequencer state into the datapath control word.
module acc_seq_decode
    import acc_seq_pkg::*;
(
    input  state_t state,
    input  op_t    op,
    output ctrl_t  ctrl
);

    // NOTE: every field gets its idle value before the case, so states that do
    // not touch a field cannot leave it unassigned and infer a latch.
    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (state)
            ST_LOADA: ctrl.n_la = 1'b0;
            ST_LOADB: ctrl.n_lb = 1'b0;
            ST_EXEC: begin
                ctrl.eu   = 1'b1;
                ctrl.n_la = 1'b0;
                ctrl.sub  = (op == OP_SUB);
            end
            ST_SHOW:  ctrl.bus_sel = 1'b0;
            default:  ;
        endcase
    end

endmodule

// File: rtl/accumulator_sequencer.sv
// Micro-sequencer stepping single-word commands through fixed T-states to drive
// the adder/accumulator control pins and capture the ALU flags.
module accumulator_sequencer
    import acc_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int OPW           = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    input  logic [OPW-1:0] cmd_op,
    output logic           cmd_ready,
    input  logic           alu_cf,
    input  logic           alu_zf,
    output logic           bus_sel,
    output logic           n_la,
    output logic           n_lb,
    output logic           ea,
    output logic           eu,
    output logic           sub,
    output logic           busy,
    output logic           done,
    output logic           flag_c,
    output logic           flag_z,
    output logic           err
);

    localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYCLES - 1);
    localparam cnt_t SHOW_LOAD   = cnt_t'(SHOW_CYCLES - 1);

    state_t state;
    state_t state_nxt;
    op_t    op_q;
    op_t    op_in;
    cnt_t   cnt;
    cnt_t   cnt_nxt;
    ctrl_t  ctrl;
    logic   accept;

    assign op_in     = op_t'(cmd_op);
    assign cmd_ready = rst_n && (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = entry_state(op_in);
                    cnt_nxt   = (entry_state(op_in) == ST_SHOW) ? SHOW_LOAD : SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = (op_q == OP_LDA) ? ST_LOADA : ST_LOADB;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_LOADA: state_nxt = ST_DONE;
            ST_LOADB: state_nxt = is_arith_load(op_q) ? ST_EXEC : ST_DONE;
            ST_EXEC:  state_nxt = ST_FLAG;
            ST_FLAG:  state_nxt = ST_DONE;
            ST_SHOW: begin
                if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            cnt    <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_q <= op_in;
            end
            // The ALU registers its flags, so they reflect EXEC during FLAG.
            if (state == ST_FLAG) begin
                flag_c <= alu_cf;
                flag_z <= alu_zf;
            end
        end
    end

    acc_seq_decode u_decode (
        .state (state),
        .op    (op_q),
        .ctrl  (ctrl)
    );

    assign bus_sel = ctrl.bus_sel && rst_n;
    assign n_la    = ctrl.n_la;
    assign n_lb    = ctrl.n_lb;
    assign ea      = ctrl.ea;
    assign eu      = ctrl.eu;
    assign sub     = ctrl.sub;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = done && (op_q == OP_RSV);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Drives random command streams into the sequencer with a small 8-bit adder
// datapath attached, and checks timing, control pulses and results against a model.
module tb_accumulator_sequencer;
    import acc_seq_pkg::*;

    localparam int SETTLE = 3;
    localparam int N_RAND = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic       cmd_ready;
    logic       alu_cf = 1'b0;
    logic       alu_zf = 1'b0;
    logic       bus_sel, n_la, n_lb, ea, eu, sub, busy, done, flag_c, flag_z, err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    accumulator_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .OPW           (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .alu_cf    (alu_cf),
        .alu_zf    (alu_zf),
        .bus_sel   (bus_sel),
        .n_la      (n_la),
        .n_lb      (n_lb),
        .ea        (ea),
        .eu        (eu),
        .sub       (sub),
        .busy      (busy),
        .done      (done),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .err       (err)
    );

    // Datapath the sequencer controls: ui_in buffer, A, B, ALU with registered flags.
    logic [7:0] ui_in = 8'h00;
    logic [7:0] ui_buf = 8'h00;
    logic [7:0] reg_a = 8'h00;
    logic [7:0] reg_b = 8'h00;
    logic [7:0] bus, uo_out;
    logic [8:0] alu_sum;

    always_comb begin
        alu_sum = sub ? ({1'b0, reg_a} + {1'b0, ~reg_b} + 9'd1)
                      : ({1'b0, reg_a} + {1'b0, reg_b});
        bus     = eu ? alu_sum[7:0] : (ea ? reg_a : ui_buf);
        uo_out  = bus_sel ? bus : reg_a;
    end

    always_ff @(posedge clk) begin
        ui_buf <= ui_in;
        if (!n_la) reg_a <= bus;
        if (!n_lb) reg_b <= bus;
        alu_cf <= alu_sum[8];
        alu_zf <= (alu_sum[7:0] == 8'h00);
    end

    // Reference model: architectural effect of each command.
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_latency(input logic [2:0] op);
        case (op)
            OP_LDA, OP_LDB: return SETTLE + 2;
            OP_ADD, OP_SUB: return SETTLE + 4;
            OP_ACC, OP_OUT: return 3;
            default:        return 1;
        endcase
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [7:0] val);
        logic [8:0] s;
        case (op)
            OP_LDA: m_a = val;
            OP_LDB: m_b = val;
            OP_ADD, OP_ACC: begin
                if (op == OP_ADD) m_b = val;
                s   = {1'b0, m_a} + {1'b0, m_b};
                m_a = s[7:0];
                m_c = s[8];
                m_z = (s[7:0] == 8'h00);
            end
            OP_SUB: begin
                m_b = val;
                m_c = (m_a >= m_b);
                m_a = m_a - m_b;
                m_z = (m_a == 8'h00);
            end
            default: ;
        endcase
    endtask

    // Starts and ends on a falling edge. With hold set, cmd_valid stays high
    // carrying next_op so the following command is offered back-to-back.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] val,
                           input bit hold, input logic [2:0] next_op);
        int w, lat, la_low, lb_low, sub_hi, sub_bad, show, both_low, ea_hi;
        int early_rdy, idle_mid, out_bad;
        w = 0; lat = 0; la_low = 0; lb_low = 0; sub_hi = 0; sub_bad = 0; show = 0;
        both_low = 0; ea_hi = 0; early_rdy = 0; idle_mid = 0; out_bad = 0;

        cmd_valid = 1'b1;
        cmd_op    = op;
        ui_in     = val;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_to_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        if (hold) cmd_op = next_op;
        else      cmd_valid = 1'b0;

        model_apply(op, val);
        do begin
            @(negedge clk);
            lat++;
            if (!n_la) la_low++;
            if (!n_lb) lb_low++;
            if (!n_la && !n_lb) both_low++;
            if (sub) sub_hi++;
            if (sub && !eu) sub_bad++;
            if (ea) ea_hi++;
            if (cmd_ready) early_rdy++;
            if (!busy) idle_mid++;
            if (!bus_sel) begin
                show++;
                if (uo_out !== m_a) out_bad++;
            end
        end while (!done && lat < 40);

        check("done_seen", done, 1);
        check("latency", lat, exp_latency(op));
        check("n_la_pulses", la_low,
              (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_ACC) ? 1 : 0);
        check("n_lb_pulses", lb_low, (op == OP_LDB || op == OP_ADD || op == OP_SUB) ? 1 : 0);
        check("sub_cycles", sub_hi, (op == OP_SUB) ? 1 : 0);
        check("sub_outside_exec", sub_bad, 0);
        check("show_cycles", show, (op == OP_OUT) ? 2 : 0);
        check("uo_out_shown", out_bad, 0);
        check("la_lb_overlap", both_low, 0);
        check("ea_asserted", ea_hi, 0);
        check("ready_while_busy", early_rdy, 0);
        check("busy_gap", idle_mid, 0);
        check("err_pulse", err, (op == OP_RSV) ? 1 : 0);
        check("reg_a", reg_a, m_a);
        check("flag_c", flag_c, m_c);
        check("flag_z", flag_z, m_z);

        @(negedge clk);
        check("idle_done_low", done, 0);
        check("idle_err_low", err, 0);
        check("idle_busy_low", busy, 0);
        check("idle_ready", cmd_ready, 1);
    endtask

    task automatic reset_during_exec(input logic [7:0] val);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        ui_in     = val;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!eu && w < 40);
        check("rst_exec_reached", eu, 1);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_n_la", n_la, 1);
        check("rst_eu", eu, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flag_c", flag_c, 0);
        check("rst_flag_z", flag_z, 0);
        check("rst_ready", cmd_ready, 0);
        // The load strobe was still low going into the reset edge, so A took the sum.
        m_b = val;
        m_a = m_a + val;
        m_c = 1'b0;
        m_z = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", cmd_ready, 1);
        check("rst_reg_a", reg_a, m_a);
    endtask

    logic [2:0] ops[N_RAND];
    logic [7:0] vals[N_RAND];

    initial begin
        // Reset with a command offered: nothing may be accepted.
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_LDA;
        repeat (2) @(posedge clk);
        #1;
        check("reset_n_la", n_la, 1);
        check("reset_n_lb", n_lb, 1);
        check("reset_ea_eu_sub", {ea, eu, sub}, 3'b000);
        check("reset_bus_sel", bus_sel, 0);
        check("reset_busy_done_err", {busy, done, err}, 3'b000);
        check("reset_flags", {flag_c, flag_z}, 2'b00);
        check("reset_ready", cmd_ready, 0);
        @(negedge clk);
        check("reset_no_accept", busy, 0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_reset_ready", cmd_ready, 1);
        check("post_reset_bus_sel", bus_sel, 1);

        // Directed sequences.
        run_cmd(OP_LDA, 8'h05, 1'b0, OP_NOP);
        run_cmd(OP_LDB, 8'h03, 1'b0, OP_NOP);
        run_cmd(OP_ADD, 8'h03, 1'b0, OP_NOP);
        run_cmd(OP_LDA, 8'h10, 1'b0, OP_NOP);
        run_cmd(OP_SUB, 8'h10, 1'b0, OP_NOP);
        check("sub_equal_a", reg_a, 8'h00);
        check("sub_equal_flags", {flag_c, flag_z}, 2'b11);
        run_cmd(OP_LDA, 8'hFF, 1'b0, OP_NOP);
        run_cmd(OP_ADD, 8'h01, 1'b0, OP_NOP);
        check("wrap_a", reg_a, 8'h00);
        check("wrap_flags", {flag_c, flag_z}, 2'b11);
        run_cmd(OP_OUT, 8'h00, 1'b0, OP_NOP);
        run_cmd(OP_ADD, 8'h22, 1'b1, OP_RSV);
        run_cmd(OP_RSV, 8'h99, 1'b1, OP_ACC);
        run_cmd(OP_ACC, 8'h00, 1'b0, OP_NOP);
        run_cmd(OP_NOP, 8'h00, 1'b0, OP_NOP);

        reset_during_exec(8'h07);
        run_cmd(OP_LDA, 8'h5A, 1'b0, OP_NOP);

        // Random command stream, sometimes back-to-back.
        foreach (ops[i]) begin
            ops[i]  = 3'($urandom_range(0, 7));
            vals[i] = 8'($urandom);
        end
        for (int i = 0; i < N_RAND; i++) begin
            if (i + 1 < N_RAND && $urandom_range(0, 1) == 1)
                run_cmd(ops[i], vals[i], 1'b1, ops[i+1]);
            else
                run_cmd(ops[i], vals[i], 1'b0, OP_NOP);
        end
        cmd_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
